// File: rtl/rx_iq_byte_packer.sv
// rx_iq_byte_packer: FIFO-buffered serializer turning 24-bit I/Q pairs into 6-byte frames.
// Define RX_IQ_OVF_COUNT_EN to add the saturating 16-bit dropped-pair counter ovf_count.
module rx_iq_byte_packer #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                in_strobe,
  input  logic [23:0]         in_I,
  input  logic [23:0]         in_Q,
  input  logic                byte_ready,
  output logic                byte_valid,
  output logic [7:0]          byte_data,
  output logic                byte_last,
  output logic [DEPTH_LOG2:0] fill_level,
  output logic                overflow,
`ifdef RX_IQ_OVF_COUNT_EN
  output logic [15:0]         ovf_count,
`endif
  input  logic                clear_overflow
);

  localparam int                  DEPTH      = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [47:0]           r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic [47:0]           r_shift;
  logic [2:0]            r_byte_idx;
  logic                  r_overflow;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_drop;
  logic w_pop;
  logic w_xfer;

  assign w_full  = (r_count == FULL_LEVEL);
  assign w_empty = (r_count == '0);
  // A full FIFO drops the pair even if a pop frees a slot on the same edge.
  assign w_push  = in_strobe && !w_full;
  assign w_drop  = in_strobe && w_full;
  assign w_xfer  = byte_valid && byte_ready;

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    byte_valid   = 1'b0;
    byte_last    = 1'b0;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: if (!w_empty) w_next_state = LOAD;
      LOAD: begin
        w_pop        = !w_empty;
        w_next_state = w_empty ? IDLE : SEND;
      end
      SEND: begin
        byte_valid = 1'b1;
        byte_last  = (r_byte_idx == 3'd5);
        if (byte_ready && byte_last) w_next_state = w_empty ? IDLE : LOAD;
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign byte_data  = byte_valid ? r_shift[47:40] : 8'h00;
  assign fill_level = r_count;
  assign overflow   = r_overflow;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_shift    <= '0;
      r_byte_idx <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_pop) begin
        r_shift    <= r_mem[r_rd_ptr];
        r_byte_idx <= '0;
      end else if (w_xfer) begin
        r_shift    <= {r_shift[39:0], 8'h00};
        r_byte_idx <= r_byte_idx + 1'b1;
      end
      if (w_drop)              r_overflow <= 1'b1;
      else if (clear_overflow) r_overflow <= 1'b0;
    end
  end

  // NOTE: storage has no reset; occupancy and pointers alone decide what is valid.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= {in_I, in_Q};
  end

`ifdef RX_IQ_OVF_COUNT_EN
  logic [15:0] r_ovf_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf_count <= '0;
    end else if (clear_overflow) begin
      r_ovf_count <= w_drop ? 16'd1 : 16'd0;
    end else if (w_drop && (r_ovf_count != 16'hFFFF)) begin
      r_ovf_count <= r_ovf_count + 1'b1;
    end
  end

  assign ovf_count = r_ovf_count;
`endif

endmodule
